// File: rtl/gs_capture_sequencer.sv
// Command-driven acquisition sequencer: pops commands, sweeps a source register
// window per enabled channel and streams samples (optionally with headers) out.
module gs_capture_sequencer #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned HEADER_EN = 1
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic [31:0]       i32CmdData,
    input  logic              iCmdEmpty,
    output logic              oCmdRdEn,
    output logic [ADDR_W-1:0] oAddr,
    output logic [7:0]        o8SignSel,
    output logic [2:0]        oChSel,
    input  logic [DATA_W-1:0] iData,
    output logic              oWrEn,
    output logic [DATA_W-1:0] oWrData,
    input  logic              iWrFull,
    input  logic              iAbort,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErr
);

    typedef enum logic [3:0] {
        IDLE, FETCH, LATCH, CHECK, HDR, ADDR, WAIT, WRITE, NEXTCH, DONE
    } state_t;

    localparam logic [7:0] CH_LIM    = 8'((9'd1 << NUM_CH) - 9'd1);
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    state_t              state_q;
    logic [31:0]         cmd_q;
    logic [7:0]          sel_q;
    logic [2:0]          ch_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          idx_q;
    logic [1:0]          wait_q;
    logic [DATA_W-1:0]   hold_q;
    logic                held_q;
    logic                rd_en_q;
    logic                wr_en_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                done_q;
    logic                err_q;

    logic [7:0] start_w;
    logic [7:0] len_w;
    logic [7:0] mask8_w;
    logic [2:0] first_ch_d;
    logic [2:0] next_ch_d;
    logic       next_vld_d;

    assign start_w = cmd_q[23:16];
    assign len_w   = cmd_q[15:8];
    assign mask8_w = cmd_q[7:0] & CH_LIM;

    // Scan from the top bit down so the last hit is the lowest qualifying channel.
    always_comb begin
        first_ch_d = '0;
        next_ch_d  = '0;
        next_vld_d = 1'b0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (mask8_w[3'(i - 1)]) begin
                first_ch_d = 3'(i - 1);
                if (3'(i - 1) > ch_q) begin
                    next_ch_d  = 3'(i - 1);
                    next_vld_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            sel_q     <= '0;
            ch_q      <= '0;
            addr_q    <= '0;
            idx_q     <= '0;
            wait_q    <= '0;
            hold_q    <= '0;
            held_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            if (iAbort && state_q != IDLE) begin
                state_q <= IDLE;
                sel_q   <= '0;
                ch_q    <= '0;
                addr_q  <= '0;
                idx_q   <= '0;
                held_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (!iCmdEmpty) begin
                            rd_en_q <= 1'b1;
                            state_q <= FETCH;
                        end
                    end
                    FETCH: state_q <= LATCH;
                    LATCH: begin
                        cmd_q   <= i32CmdData;
                        state_q <= CHECK;
                    end
                    CHECK: begin
                        if (len_w == 8'd0 || mask8_w == 8'd0) begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            sel_q   <= cmd_q[31:24];
                            ch_q    <= first_ch_d;
                            idx_q   <= '0;
                            state_q <= (HEADER_EN != 0) ? HDR : ADDR;
                        end
                    end
                    HDR: begin
                        if (!iWrFull) begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= DATA_W'({4'hA, 1'b0, ch_q, len_w});
                            state_q   <= ADDR;
                        end
                    end
                    ADDR: begin
                        addr_q  <= ADDR_W'(start_w + idx_q);
                        wait_q  <= '0;
                        state_q <= WAIT;
                    end
                    WAIT: begin
                        if (wait_q == WAIT_LAST) begin
                            state_q <= WRITE;
                        end else begin
                            wait_q <= wait_q + 2'd1;
                        end
                    end
                    WRITE: begin
                        // First stalled cycle captures the sample; later cycles keep it.
                        if (!iWrFull) begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= held_q ? hold_q : iData;
                            held_q    <= 1'b0;
                            idx_q     <= idx_q + 8'd1;
                            state_q   <= (idx_q < len_w - 8'd1) ? ADDR : NEXTCH;
                        end else if (!held_q) begin
                            hold_q <= iData;
                            held_q <= 1'b1;
                        end
                    end
                    NEXTCH: begin
                        idx_q <= '0;
                        if (next_vld_d) begin
                            ch_q    <= next_ch_d;
                            state_q <= (HEADER_EN != 0) ? HDR : ADDR;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                    DONE: begin
                        sel_q   <= '0;
                        ch_q    <= '0;
                        addr_q  <= '0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign oCmdRdEn  = rd_en_q;
    assign oAddr     = addr_q;
    assign o8SignSel = sel_q;
    assign oChSel    = ch_q;
    assign oWrEn     = wr_en_q;
    assign oWrData   = wr_data_q;
    assign oBusy     = (state_q != IDLE);
    assign oDone     = done_q;
    assign oErr      = err_q;

endmodule

// File: tb/tb_gs_capture_sequencer.sv
// Scoreboard bench for gs_capture_sequencer: instance A (RD_LAT=1, headers) and
// instance B (RD_LAT=3, no headers) with modelled command FIFOs and signal sources.
`timescale 1ns/1ps
module tb_gs_capture_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A signals
    logic [31:0] cdata_a = '0;
    logic        cempty_a, crd_a, wr_a, full_a, abort_a, busy_a, done_a, err_a;
    logic [7:0]  addr_a, sel_a;
    logic [2:0]  ch_a;
    logic [15:0] idata_a = '0;
    logic [15:0] wdata_a;
    // Instance B signals
    logic [31:0] cdata_b = '0;
    logic        cempty_b, crd_b, wr_b, busy_b, done_b, err_b;
    logic        full_b  = 1'b0;
    logic        abort_b = 1'b0;
    logic [7:0]  addr_b, sel_b;
    logic [2:0]  ch_b;
    logic [15:0] idata_b = '0;
    logic [15:0] pb0 = '0;
    logic [15:0] pb1 = '0;
    logic [15:0] wdata_b;

    gs_capture_sequencer #(
        .DATA_W(16), .ADDR_W(8), .NUM_CH(4), .RD_LAT(1), .HEADER_EN(1)
    ) dut_a (
        .iClk(clk), .iReset(rst), .i32CmdData(cdata_a), .iCmdEmpty(cempty_a),
        .oCmdRdEn(crd_a), .oAddr(addr_a), .o8SignSel(sel_a), .oChSel(ch_a),
        .iData(idata_a), .oWrEn(wr_a), .oWrData(wdata_a), .iWrFull(full_a),
        .iAbort(abort_a), .oBusy(busy_a), .oDone(done_a), .oErr(err_a)
    );

    gs_capture_sequencer #(
        .DATA_W(16), .ADDR_W(8), .NUM_CH(4), .RD_LAT(3), .HEADER_EN(0)
    ) dut_b (
        .iClk(clk), .iReset(rst), .i32CmdData(cdata_b), .iCmdEmpty(cempty_b),
        .oCmdRdEn(crd_b), .oAddr(addr_b), .o8SignSel(sel_b), .oChSel(ch_b),
        .iData(idata_b), .oWrEn(wr_b), .oWrData(wdata_b), .iWrFull(full_b),
        .iAbort(abort_b), .oBusy(busy_b), .oDone(done_b), .oErr(err_b)
    );

    // Non-FWFT command FIFOs: data appears the cycle after the pop strobe.
    logic [31:0] cq_a [16];
    logic [31:0] cq_b [16];
    logic [3:0]  cwp_a = '0, crp_a = '0, cwp_b = '0, crp_b = '0;
    assign cempty_a = (cwp_a == crp_a);
    assign cempty_b = (cwp_b == crp_b);

    // Source sample = {channel, select[4:0], address}, delayed by RD_LAT cycles.
    function automatic logic [15:0] src(logic [2:0] c, logic [7:0] s, logic [7:0] a);
        return {c, s[4:0], a};
    endfunction

    always @(posedge clk) begin
        if (crd_a && !cempty_a) begin
            cdata_a <= cq_a[crp_a];
            crp_a   <= crp_a + 4'd1;
        end
        if (crd_b && !cempty_b) begin
            cdata_b <= cq_b[crp_b];
            crp_b   <= crp_b + 4'd1;
        end
        idata_a <= src(ch_a, sel_a, addr_a);
        pb0     <= src(ch_b, sel_b, addr_b);
        pb1     <= pb0;
        idata_b <= pb1;
    end

    task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    endtask

    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];
    int unsigned wr_cnt_a = 0, rd_cnt_a = 0, done_cnt_a = 0, err_cnt_a = 0;
    int unsigned wr_cnt_b = 0, done_cnt_b = 0;
    int unsigned done_at_rd_a = 0, err_cyc_a = 0, last_wr_b = 0, gap_b = 0;
    logic [7:0]  sel_at_done_a = '0;
    logic        busy_at_err_a = 1'b1;

    // Monitor: event counters and in-order comparison of every output write.
    initial begin : monitor
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (crd_a) begin
                rd_cnt_a++;
                done_at_rd_a = done_cnt_a;
            end
            if (done_a) begin
                done_cnt_a++;
                sel_at_done_a = sel_a;
            end
            if (err_a) begin
                err_cnt_a++;
                busy_at_err_a = busy_a;
                err_cyc_a     = cyc;
            end
            if (wr_a) begin
                wr_cnt_a++;
                check("a_write_while_full", 64'(full_a), 64'd0);
                if (exp_a.size() > 0) begin
                    e = exp_a.pop_front();
                    check("a_wdata", 64'(wdata_a), 64'(e));
                end else begin
                    check("a_unexpected_write", 64'(wdata_a), 64'hFFFF_FFFF);
                end
            end
            if (done_b) done_cnt_b++;
            if (wr_b) begin
                if (wr_cnt_b == 1) gap_b = cyc - last_wr_b;
                last_wr_b = cyc;
                wr_cnt_b++;
                if (exp_b.size() > 0) begin
                    e = exp_b.pop_front();
                    check("b_wdata", 64'(wdata_b), 64'(e));
                end else begin
                    check("b_unexpected_write", 64'(wdata_b), 64'hFFFF_FFFF);
                end
            end
        end
    end

    function automatic int unsigned get_cnt(int unsigned which);
        case (which)
            0:       return done_cnt_a;
            1:       return wr_cnt_a;
            2:       return err_cnt_a;
            default: return done_cnt_b;
        endcase
    endfunction

    task automatic wait_cnt(int unsigned which, int unsigned target, string nm);
        int unsigned n;
        n = 0;
        while (get_cnt(which) < target && n < 4000) begin
            @(posedge clk);
            n++;
        end
        check(nm, 64'(get_cnt(which) >= target), 64'd1);
    endtask

    task automatic push_a(logic [31:0] c);
        cq_a[cwp_a] = c;
        cwp_a = cwp_a + 4'd1;
    endtask

    task automatic exp_words_a(logic [15:0] w[$]);
        foreach (w[i]) exp_a.push_back(w[i]);
    endtask

    initial begin : stim
        int unsigned push_cyc;
        rst = 1'b1;
        full_a = 1'b0;
        abort_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs_a", 64'({crd_a, addr_a, sel_a, ch_a, wr_a, wdata_a, busy_a, done_a, err_a}), 64'd0);
        check("reset_outs_b", 64'({crd_b, addr_b, sel_b, ch_b, wr_b, wdata_b, busy_b, done_b, err_b}), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single channel with header; B runs a RD_LAT=3 two-channel sweep alongside.
        exp_words_a('{16'hA004, 16'h0510, 16'h0511, 16'h0512, 16'h0513});
        push_a(32'h0510_0401);
        foreach (exp_b[i]) exp_b.delete(i);
        exp_b = '{16'h2930, 16'h2931, 16'h2932, 16'h4930, 16'h4931, 16'h4932};
        cq_b[cwp_b] = 32'h0930_0306;
        cwp_b = cwp_b + 4'd1;
        wait_cnt(0, 1, "t1_done_timeout");
        #1;
        check("t1_sel_during_cmd", 64'(sel_at_done_a), 64'h05);
        check("t1_writes", 64'(wr_cnt_a), 64'd5);
        check("t1_rd_pulses", 64'(rd_cnt_a), 64'd1);
        check("t1_cleared_after_done", 64'({busy_a, sel_a, addr_a, ch_a}), 64'd0);
        wait_cnt(3, 1, "b_done_timeout");
        check("b_writes", 64'(wr_cnt_b), 64'd6);
        check("b_sample_period", 64'(gap_b), 64'd5);

        // Address wrap across two channels.
        exp_words_a('{16'hA004, 16'h03FE, 16'h03FF, 16'h0300, 16'h0301,
                      16'hA204, 16'h43FE, 16'h43FF, 16'h4300, 16'h4301});
        push_a(32'h03FE_0405);
        wait_cnt(0, 2, "t2_done_timeout");
        #1;
        check("t2_writes", 64'(wr_cnt_a), 64'd15);

        // Rejected commands: zero length, then a mask outside NUM_CH.
        push_cyc = cyc;
        push_a(32'h0100_0001);
        wait_cnt(2, 1, "t3_err1_timeout");
        check("t3_err_latency", 64'(err_cyc_a - push_cyc), 64'd4);
        check("t3_busy_at_err1", 64'(busy_at_err_a), 64'd0);
        #1;
        push_a(32'h0100_04F0);
        wait_cnt(2, 2, "t3_err2_timeout");
        check("t3_busy_at_err2", 64'(busy_at_err_a), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check("t3_no_writes", 64'(wr_cnt_a), 64'd15);
        check("t3_rd_pulses", 64'(rd_cnt_a), 64'd4);
        check("t3_no_done", 64'(done_cnt_a), 64'd2);

        // Backpressure for 7 cycles on the second sample.
        exp_words_a('{16'hA103, 16'h2720, 16'h2721, 16'h2722});
        push_a(32'h0720_0302);
        wait_cnt(1, 17, "t4_wr_timeout");
        #1 full_a = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("t4_stalled", 64'(wr_cnt_a), 64'd17);
        full_a = 1'b0;
        wait_cnt(0, 3, "t4_done_timeout");
        check("t4_writes", 64'(wr_cnt_a), 64'd19);

        // Abort after two writes of an L=8 command; queued command follows.
        exp_words_a('{16'hA008, 16'h0240, 16'hA302, 16'h6480, 16'h6481});
        push_a(32'h0240_0801);
        push_a(32'h0480_0208);
        wait_cnt(1, 21, "t5_wr_timeout");
        #1 abort_a = 1'b1;
        @(posedge clk);
        #1 abort_a = 1'b0;
        check("t5_idle_after_abort", 64'(busy_a), 64'd0);
        check("t5_no_done_on_abort", 64'(done_cnt_a), 64'd3);
        wait_cnt(0, 4, "t5_done_timeout");
        check("t5_writes", 64'(wr_cnt_a), 64'd24);
        check("t5_rd_pulses", 64'(rd_cnt_a), 64'd7);

        // Two queued commands back to back.
        exp_words_a('{16'hA002, 16'h0100, 16'h0101, 16'hA102, 16'h2100, 16'h2101,
                      16'hA001, 16'h1FFF});
        push_a(32'h0100_0203);
        push_a(32'h1FFF_0101);
        wait_cnt(0, 6, "t6_done_timeout");
        check("t6_rd_pulses", 64'(rd_cnt_a), 64'd9);
        check("t6_second_pop_after_done", 64'(done_at_rd_a), 64'd5);
        check("t6_writes", 64'(wr_cnt_a), 64'd32);

        // Reset in the middle of a command.
        exp_words_a('{16'hA008, 16'h0A50, 16'h0A51});
        push_a(32'h0A50_0801);
        wait_cnt(1, 35, "t7_wr_timeout");
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t7_reset_outs", 64'({crd_a, addr_a, sel_a, ch_a, wr_a, wdata_a, busy_a, done_a, err_a}), 64'd0);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("t7_no_writes_after_reset", 64'(wr_cnt_a), 64'd35);
        check("t7_no_pops_after_reset", 64'(rd_cnt_a), 64'd10);
        check("t7_idle", 64'(busy_a), 64'd0);

        check("a_leftover_expected", 64'(exp_a.size()), 64'd0);
        check("b_leftover_expected", 64'(exp_b.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gs_capture_sequencer.md
Name: gs_capture_sequencer

Overview:
- Command-driven acquisition sequencer for raw-signal readout.
- Pops 32-bit commands from a standard (non-FWFT) command FIFO.
- For each enabled channel, sweeps a register window of the signal source and pushes the samples into an output FIFO.
- Generalises single-channel fixed-length readout: adds parametrised width, channel count, programmable start and length, source read latency, output backpressure, optional per-channel header words, abort, and error reporting.

Parameters:
- DATA_W, 16: sample and output word width; must be >= 16.
- ADDR_W, 8: source address width; must be <= 8.
- NUM_CH, 4: number of channels, 1..8.
- RD_LAT, 1: cycles from oAddr change to valid iData, 1..4.
- HEADER_EN, 1: 1 = emit one header word before each channel block.

Ports:
- iClk  in  1  clock, all logic on the rising edge.
- iReset  in  1  synchronous, active-high reset.
- i32CmdData  in  32  command word; valid the cycle after oCmdRdEn.
- iCmdEmpty  in  1  command FIFO empty.
- oCmdRdEn  out  1  one-cycle pop strobe.
- oAddr  out  ADDR_W  source register address.
- o8SignSel  out  8  signal selector, held for the whole command.
- oChSel  out  3  active channel index.
- iData  in  DATA_W  source read data.
- oWrEn  out  1  output FIFO write strobe.
- oWrData  out  DATA_W  output word.
- iWrFull  in  1  output FIFO full.
- iAbort  in  1  abort current command.
- oBusy  out  1  high in any state except IDLE.
- oDone  out  1  one-cycle pulse when a command completes.
- oErr  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset: synchronous on iReset. All outputs 0, state IDLE, internal counters 0.
- Command format:
  - [31:24] signal select.
  - [23:16] start address.
  - [15:8] length L, 1..255.
  - [7:0] channel mask; only bits [NUM_CH-1:0] are used.
- States: IDLE, FETCH, LATCH, CHECK, HDR, ADDR, WAIT, WRITE, NEXTCH, DONE.
- IDLE: when iCmdEmpty=0, go to FETCH.
- FETCH: assert oCmdRdEn for exactly one cycle, then go to LATCH.
- LATCH: register i32CmdData, then go to CHECK.
- CHECK: if L=0 or the masked channel mask is 0, pulse oErr and return to IDLE with no writes. Otherwise:
  - Drive o8SignSel.
  - Select the lowest set channel.
  - Go to HDR if HEADER_EN=1, else to ADDR.
- HDR: when iWrFull=0, write {4'hA, 1'b0, ch[2:0], L[7:0]}, zero-extended to DATA_W.
- ADDR: oAddr = (start + idx) mod 2^ADDR_W, so the window wraps around the address space. Then wait RD_LAT cycles in WAIT.
- WRITE: hold iData in a register. When iWrFull=0, pulse oWrEn with that data and increment idx.
  - If idx < L-1, go back to ADDR.
  - Otherwise go to NEXTCH.
- NEXTCH: select the next higher set mask bit and reset idx=0.
  - If another channel is set, go to HDR or ADDR.
  - Otherwise go to DONE.
- DONE: pulse oDone for one cycle, clear oAddr, oChSel and o8SignSel, return to IDLE.
- Backpressure: while iWrFull=1, stall in HDR or WRITE with the captured data held. oWrEn is never asserted while iWrFull=1.
- Abort: iAbort=1 in any busy state returns to IDLE next cycle.
  - No oDone is pulsed.
  - oWrEn is deasserted that cycle.
  - Words already written stay in the output FIFO.
  - Abort in IDLE has no effect.
- Reset mid-command discards the command; there is no FIFO pop or write afterwards until a new command arrives.
- Commands never overlap; the next command is fetched only from IDLE.
- Output word count per command = (popcount(mask) x L) + (HEADER_EN x popcount(mask)).
- Latency with no stalls:
  - CHECK is reached 3 cycles after iCmdEmpty falls in IDLE.
  - Each sample takes RD_LAT+2 cycles.

Test Plan:
- Cmd 0x05_10_04_01, HEADER_EN=1, RD_LAT=1 -> one rd_en pulse; writes 0xA004, then data at addr 0x10..0x13; o8SignSel=0x05; oDone once; 5 writes total.
- Cmd start=0xFE, L=4, mask=0x05 -> channel 0 then channel 2; addresses FE, FF, 00, 01 for each; 10 writes; headers 0xA004 and 0xA204.
- Cmd L=0, and separately mask=0xF0 with NUM_CH=4 -> oErr pulse, zero writes, oBusy low 1 cycle later.
- Hold iWrFull=1 for 7 cycles during the 2nd sample -> no oWrEn while full; sample value preserved; total count unchanged.
- Assert iAbort after the 2nd write of an L=8 cmd -> IDLE next cycle, no oDone; the next queued cmd executes normally.
- Two queued commands with iCmdEmpty low throughout -> exactly two rd_en pulses, the second only after the first oDone; RD_LAT=3 run shows data sampled 3 cycles after address.
